// File: rtl/ula_pkg.sv
// Shared ULA opcode map and arbiter FSM encoding.
package ula_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_MULT2 = 5'd2;
  localparam logic [4:0] OP_DIV2  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_NOT   = 5'd6;
  localparam logic [4:0] OP_EQ    = 5'd7;
  localparam logic [4:0] OP_LT    = 5'd8;
  localparam logic [4:0] OP_NE    = 5'd9;
  localparam logic [4:0] OP_JMP   = 5'd10;
  localparam logic [4:0] OP_MAX   = 5'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping to bit 0.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign hi_mask[gi] = (IW'(gi) > ptr);
    end
  endgenerate

  // Prefer requesters above the pointer; otherwise wrap around to the lowest set bit.
  assign req_hi = req & hi_mask;
  assign pick   = (|req_hi) ? req_hi : req;
  assign grant  = pick & (~pick + N'(1));
  assign any    = |req;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA among NREQ requesters,
// one transaction in flight: IDLE -> ISSUE -> RESP.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int OPW  = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*OPW-1:0]  req_op,
  input  logic [NREQ-1:0]      req_imm,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ*DW-1:0]   req_ext,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DW-1:0]        rsp_result,
  output logic                 rsp_true,
  output logic                 rsp_err,
  output logic                 ula_reset,
  output logic [OPW-1:0]       ula_op,
  output logic                 ula_imm,
  output logic [DW-1:0]        ula_lido1,
  output logic [DW-1:0]        ula_lido2,
  output logic [DW-1:0]        ula_ext,
  input  logic [DW-1:0]        ula_result,
  input  logic                 ula_true
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_reg;
  logic [IW-1:0]   ptr_reg;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [OPW-1:0]  op_slot  [NREQ];
  logic [DW-1:0]   a_slot   [NREQ];
  logic [DW-1:0]   b_slot   [NREQ];
  logic [DW-1:0]   ext_slot [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      assign op_slot[gi]  = req_op[gi*OPW +: OPW];
      assign a_slot[gi]   = req_a[gi*DW +: DW];
      assign b_slot[gi]   = req_b[gi*DW +: DW];
      assign ext_slot[gi] = req_ext[gi*DW +: DW];
    end
  endgenerate

  rr_picker #(
    .N  (NREQ),
    .IW (IW)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_reg),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= IW'(NREQ - 1);
      gnt        <= '0;
      done       <= '0;
      rsp_result <= '0;
      rsp_true   <= 1'b0;
      rsp_err    <= 1'b0;
      ula_reset  <= 1'b1;
      ula_op     <= '0;
      ula_imm    <= 1'b0;
      ula_lido1  <= '0;
      ula_lido2  <= '0;
      ula_ext    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pick_any) begin
            ula_op    <= op_slot[pick_idx];
            ula_imm   <= req_imm[pick_idx];
            ula_lido1 <= a_slot[pick_idx];
            ula_lido2 <= b_slot[pick_idx];
            ula_ext   <= ext_slot[pick_idx];
            gnt       <= pick_gnt;
            ptr_reg   <= pick_idx;
            ula_reset <= 1'b0;
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Out-of-range opcodes leave the ULA output undefined; never let it through.
          if (ula_op > OPW'(OP_MAX)) begin
            rsp_result <= '0;
            rsp_true   <= 1'b0;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= ula_result;
            rsp_true   <= ula_true;
            rsp_err    <= 1'b0;
          end
          done      <= gnt;
          ula_reset <= 1'b1;
          state_reg <= S_RESP;
        end
        S_RESP: begin
          done      <= '0;
          gnt       <= '0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: behavioural ULA, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ula_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int OW = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*OW-1:0] req_op;
  logic [N-1:0]    req_imm;
  logic [N*DW-1:0] req_a, req_b, req_ext;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rsp_result;
  logic            rsp_true, rsp_err;
  logic            ula_reset, ula_imm;
  logic [OW-1:0]   ula_op;
  logic [DW-1:0]   ula_lido1, ula_lido2, ula_ext;
  logic [DW-1:0]   ula_result;
  logic            ula_true;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ula_arbiter #(.NREQ(N), .DW(DW), .OPW(OW)) dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op), .req_imm(req_imm),
    .req_a(req_a), .req_b(req_b), .req_ext(req_ext), .gnt(gnt), .done(done),
    .rsp_result(rsp_result), .rsp_true(rsp_true), .rsp_err(rsp_err),
    .ula_reset(ula_reset), .ula_op(ula_op), .ula_imm(ula_imm), .ula_lido1(ula_lido1),
    .ula_lido2(ula_lido2), .ula_ext(ula_ext), .ula_result(ula_result), .ula_true(ula_true)
  );

  // Behavioural ULA: returns {True, Resultado}. Undefined opcodes output a junk latch value.
  function automatic logic [DW:0] alu_f(input logic [OW-1:0] op, input logic imm,
                                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [DW-1:0] e);
    logic [DW-1:0] b2;
    logic t;
    b2 = imm ? e : b;
    case (op)
      5'd0:    return {1'b0, a + b2};
      5'd1:    return {1'b0, a - b2};
      5'd2:    return {1'b0, a << 1};
      5'd3:    return {1'b0, DW'($signed(a) >>> 1)};
      5'd4:    return {1'b0, a & b2};
      5'd5:    return {1'b0, a | b2};
      5'd6:    return {1'b0, ~a};
      5'd7:    begin t = (a == b2); return {t, DW'(t)}; end
      5'd8:    begin t = ($signed(a) < $signed(b2)); return {t, DW'(t)}; end
      5'd9:    begin t = (a != b2); return {t, DW'(t)}; end
      5'd10:   return {1'b1, {DW{1'b0}}};
      default: return {1'b1, 32'hDEAD_BEEF};
    endcase
  endfunction

  logic [DW:0] ula_out;
  assign ula_out    = ula_reset ? '0 : alu_f(ula_op, ula_imm, ula_lido1, ula_lido2, ula_ext);
  assign ula_result = ula_out[DW-1:0];
  assign ula_true   = ula_out[DW];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++) begin
      if (r[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW+1:0] capture(input logic [OW-1:0] op, input logic imm,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] e);
    if (op > 5'd10) return {1'b1, 1'b0, {DW{1'b0}}};
    return {1'b0, alu_f(op, imm, a, b, e)};
  endfunction

  int            m_phase;   // 0 idle, 1 ula busy, 2 responding
  int            m_ptr;
  logic [N-1:0]  m_gnt, m_done;
  logic [DW-1:0] m_res, m_a, m_b, m_ext;
  logic          m_true, m_err, m_imm, m_ulareset;
  logic [OW-1:0] m_op;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_ptr <= N - 1; m_gnt <= '0; m_done <= '0;
      m_res <= '0; m_true <= 1'b0; m_err <= 1'b0; m_ulareset <= 1'b1;
      m_op <= '0; m_imm <= 1'b0; m_a <= '0; m_b <= '0; m_ext <= '0;
    end else if (m_phase == 0) begin
      if (req != '0) begin
        m_ptr      <= rr_pick(req, m_ptr);
        m_gnt      <= N'(1) << rr_pick(req, m_ptr);
        m_op       <= req_op[rr_pick(req, m_ptr)*OW +: OW];
        m_imm      <= req_imm[rr_pick(req, m_ptr)];
        m_a        <= req_a[rr_pick(req, m_ptr)*DW +: DW];
        m_b        <= req_b[rr_pick(req, m_ptr)*DW +: DW];
        m_ext      <= req_ext[rr_pick(req, m_ptr)*DW +: DW];
        m_ulareset <= 1'b0;
        m_phase    <= 1;
      end
    end else if (m_phase == 1) begin
      {m_err, m_true, m_res} <= capture(m_op, m_imm, m_a, m_b, m_ext);
      m_done     <= m_gnt;
      m_ulareset <= 1'b1;
      m_phase    <= 2;
    end else begin
      m_done  <= '0;
      m_gnt   <= '0;
      m_phase <= 0;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("m_gnt", gnt, m_gnt);
      chk("m_done", done, m_done);
      chk("m_result", rsp_result, m_res);
      chk("m_true", rsp_true, m_true);
      chk("m_err", rsp_err, m_err);
      chk("m_ula_reset", ula_reset, m_ulareset);
      chk("m_ula_ops", {ula_op, ula_imm, ula_lido1}, {m_op, m_imm, m_a});
      chk("m_ula_b_ext", {ula_lido2, ula_ext}, {m_b, m_ext});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_slot(input int i, input logic [OW-1:0] op, input logic imm,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] e);
    req_op[i*OW +: OW]  = op;
    req_imm[i]          = imm;
    req_a[i*DW +: DW]   = a;
    req_b[i*DW +: DW]   = b;
    req_ext[i*DW +: DW] = e;
  endtask

  task automatic wait_done(input int slot, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!done[slot] && cyc < limit);
    chk($sformatf("done%0d_seen", slot), done[slot], 1);
  endtask

  int cyc, seen0, n_rand_done;
  int order[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; req_op = '0; req_imm = '0; req_a = '0; req_b = '0; req_ext = '0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_ula_reset", ula_reset, 1);
    chk("rst_rsp", {rsp_err, rsp_true, rsp_result}, 0);
    #1 reset = 1'b0;
    @(negedge clock);

    // 1: single op, requester 0 wins first after reset
    #1 set_slot(0, 5'd0, 1'b0, 32'd5, 32'd7, 32'd0); req = 2'b01;
    @(negedge clock);
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_ula_reset_issue", ula_reset, 0);
    @(negedge clock);
    chk("t1_done", done, 2'b01);
    chk("t1_result", rsp_result, 12);
    chk("t1_true", rsp_true, 0);
    #1 req = '0;
    @(negedge clock);
    chk("t1_done_clear", done, 0);

    // 2: immediate path, LT with imm
    #1 set_slot(1, 5'd8, 1'b1, 32'd3, 32'd0, 32'd9); req = 2'b10;
    wait_done(1, 8, cyc);
    chk("t2_latency", cyc, 2);
    chk("t2_rsp", {rsp_err, rsp_true, rsp_result}, {1'b0, 1'b1, 32'd1});
    #1 req = '0;
    @(negedge clock);

    // 3: contention, both held for four transactions
    #1 set_slot(0, 5'd0, 1'b0, 32'd100, 32'd23, 32'd0);
    set_slot(1, 5'd1, 1'b0, 32'd50, 32'd8, 32'd0);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      do begin @(negedge clock); cyc++; end while (done == '0 && cyc < 10);
      chk("t3_one_done", $countones(done), 1);
      order[k] = done[1] ? 1 : 0;
      chk($sformatf("t3_result_%0d", k), rsp_result, order[k] ? 42 : 123);
      if (k > 0) chk($sformatf("t3_spacing_%0d", k), cyc, 3);
    end
    chk("t3_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b00_01_00_01);
    #1 req = '0;
    @(negedge clock);

    // 4: bad opcode forces an error response, next good op clears it
    #1 set_slot(0, 5'd15, 1'b0, 32'd1, 32'd2, 32'd0); req = 2'b01;
    wait_done(0, 8, cyc);
    chk("t4_bad_rsp", {rsp_err, rsp_true, rsp_result}, {1'b1, 1'b0, 32'd0});
    #1 req = '0;
    @(negedge clock);
    #1 set_slot(1, 5'd7, 1'b0, 32'd4, 32'd4, 32'd0); req = 2'b10;
    wait_done(1, 8, cyc);
    chk("t4_err_clear", rsp_err, 0);
    chk("t4_eq_true", rsp_true, 1);
    #1 req = '0;
    @(negedge clock);

    // 5: reset during ISSUE loses the transaction
    #1 set_slot(0, 5'd0, 1'b0, 32'd1, 32'd1, 32'd0); req = 2'b01;
    @(negedge clock);
    chk("t5_issue_gnt", gnt, 2'b01);
    #1 reset = 1'b1;
    #1;
    chk("t5_gnt_cleared", gnt, 0);
    chk("t5_ula_reset", ula_reset, 1);
    chk("t5_no_done", done, 0);
    set_slot(1, 5'd0, 1'b0, 32'd2, 32'd2, 32'd0); req = 2'b10;
    @(negedge clock);
    #1 reset = 1'b0;
    seen0 = 0; cyc = 0;
    do begin
      @(negedge clock); cyc++;
      if (done[0]) seen0 = 1;
    end while (!done[1] && cyc < 8);
    chk("t5_done1", done[1], 1);
    chk("t5_done0_never", seen0, 0);
    chk("t5_result", rsp_result, 4);
    #1 req = '0;
    @(negedge clock);

    // 6: requester drops req during ISSUE; done still pulses
    #1 set_slot(1, 5'd4, 1'b0, 32'hF0, 32'h3C, 32'd0); req = 2'b10;
    @(negedge clock);
    chk("t6_gnt", gnt, 2'b10);
    #1 req = '0;
    @(negedge clock);
    chk("t6_done", done, 2'b10);
    chk("t6_result", rsp_result, 32'h30);
    @(negedge clock);
    chk("t6_idle_gnt", gnt, 0);
    chk("t6_idle_done", done, 0);
    @(negedge clock);
    chk("t6_still_idle", gnt, 0);

    // randomized traffic against the model
    n_rand_done = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (done != '0) n_rand_done++;
      #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && done[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (req[i] && gnt[i]) begin
          if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_slot(i, ($urandom_range(0, 4) == 0) ? OW'($urandom_range(11, 31))
                                                 : OW'($urandom_range(0, 10)),
                   1'($urandom_range(0, 1)), $urandom, $urandom,
                   ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15)));
          req[i] = 1'b1;
        end
      end
    end
    chk("rand_activity", n_rand_done > 50, 1);

    #1 req = '0;
    repeat (4) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
